alu_ctrl_issue: RTL and testbench
=================================

// Module: alu_ctrl_issue
// PURPOSE
//  ID/EX-side producer of the 4-bit ALU operation code consumed by the EX-stage ALU.
//  - Decodes ALUOp and funct into the ALU code and registers it into EX.
//  - Sequences multi-cycle multiply: holds code 3 for MUL_LAT cycles and back-pressures ID via busy_o.
// PARAMETERS
//  MUL_LAT  4   cycles the ALU needs for a multiply (>=1); 1 = no wait state
//  CNT_W    3   width of the multiply wait counter; must satisfy 2**CNT_W >= MUL_LAT
// PORTS
//  clk_i      in   1  clock; all state changes on the rising edge
//  rst_i      in   1  asynchronous, active-low reset
//  valid_i    in   1  ID presents a valid instruction this cycle
//  alu_op_i   in   3  main-decoder ALUOp
//  funct_i    in   6  instruction funct field
//  stall_i    in   1  EX hold; freezes all state
//  flush_i    in   1  squash the EX slot (branch/hazard)
//  ctrl_o     out  4  registered ALU code to the EX-stage ALU
//  valid_o    out  1  ctrl_o is a completed, issuable operation this cycle
//  busy_o     out  1  multiply in progress; ID must hold its instruction
//  illegal_o  out  1  registered: current slot held an undecodable op
// BEHAVIOUR
//  Reset (rst_i=0, async): state=IDLE, ctrl_o=4'd0, valid_o=0, busy_o=0, illegal_o=0, counter=0.
//  Decode (combinational):
//   - ALUOp 000 -> 2 (add)
//   - ALUOp 001 -> 6 (sub)
//   - ALUOp 011 -> 7 (slt)
//   - ALUOp 100 -> 0 (and)
//   - ALUOp 101 -> 1 (or)
//   - ALUOp 010 (R-type) by funct: 0x20->2, 0x22->6, 0x24->0, 0x25->1, 0x2A->7, 0x27->12, 0x18->3
//   - Any other ALUOp or funct is illegal: code 4'd15, illegal=1.
//  States: IDLE, ISSUE, MUL_WAIT.
//  Priority per edge: rst_i > flush_i > stall_i > normal operation.
//  Accept: valid_i & ~busy_o & ~stall_i & ~flush_i. Latency is 1 cycle from accept to ctrl_o.
//  On accept, non-multiply (or multiply with MUL_LAT=1):
//   - Go to ISSUE.
//   - ctrl_o <= code, valid_o <= 1, illegal_o <= illegal.
//  On accept, multiply with MUL_LAT>1:
//   - Go to MUL_WAIT.
//   - ctrl_o <= 3, valid_o <= 0, busy_o <= 1, counter <= MUL_LAT-2.
//  MUL_WAIT:
//   - ctrl_o holds 3; valid_o stays 0.
//   - counter decrements once per unstalled cycle.
//   - When counter==0 at an edge: next state ISSUE, valid_o=1, busy_o=0.
//   - The multiply is therefore valid MUL_LAT cycles after accept.
//   - valid_i is ignored while busy_o=1; ID must keep holding its instruction.
//  ISSUE with no new accept: go to IDLE; valid_o <= 0; ctrl_o keeps its last value.
//  ISSUE with an accept: back-to-back issue, one op per cycle.
//  stall_i=1: state, counter, ctrl_o, valid_o, busy_o and illegal_o all hold; no accept.
//  flush_i=1 (wins over stall_i and valid_i):
//   - Next state IDLE; valid_o=0, busy_o=0, illegal_o=0, counter=0.
//   - An in-flight multiply is abandoned; a same-cycle valid_i is dropped.
//  busy_o is registered and equals (state==MUL_WAIT).
//  Reset mid-multiply returns everything to reset values immediately.
// CONFIGURATION
//  ALU_CTRL_ILLEGAL_TRAP_EN:
//   - Defined: illegal_o is sticky. It sets on the accept of an illegal op and clears only on flush_i or reset.
//     While it is set, further accepts are blocked (busy_o forced to 1).
//   - Undefined: illegal_o follows each accepted op.
//     Illegal ops issue as code 15, which the ALU resolves to result 0.
// TESTING
//  1. Reset: rst_i=0 mid-run -> all outputs 0 in the same cycle, state IDLE.
//  2. Back-to-back R-type funct 0x20, 0x22, 0x2A, 0x27 -> ctrl_o 2, 6, 7, 12 on consecutive cycles.
//     valid_o is 1 throughout; busy_o stays 0.
//  3. Multiply, MUL_LAT=4: funct 0x18 -> ctrl_o=3 next cycle; busy_o=1 for 3 cycles; valid_o=1 on the 4th.
//     An add held on valid_i is then accepted on the cycle busy_o drops.
//  4. stall_i=1 for 2 cycles during MUL_WAIT -> completion slips exactly 2 cycles; ctrl_o stays 3.
//  5. flush_i during MUL_WAIT together with valid_i=1 -> next cycle valid_o=0, busy_o=0, state IDLE.
//     The incoming op is dropped.
//  6. ALUOp 111 -> ctrl_o=15, illegal_o=1.
//     With TRAP_EN, the next valid op is blocked until flush_i, then accepted normally.

Source files
------------

// File: rtl/alu_ctrl_issue_if.sv
// ============================================================================
// Module   : alu_ctrl_issue_if
// Brief    : ID-to-EX handshake bundle for the ALU control issue stage.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface alu_ctrl_issue_if;
    logic       valid_i;
    logic [2:0] alu_op_i;
    logic [5:0] funct_i;
    logic       stall_i;
    logic       flush_i;
    logic [3:0] ctrl_o;
    logic       valid_o;
    logic       busy_o;
    logic       illegal_o;

    modport master (
        output valid_i, alu_op_i, funct_i, stall_i, flush_i,
        input  ctrl_o, valid_o, busy_o, illegal_o
    );

    modport slave (
        input  valid_i, alu_op_i, funct_i, stall_i, flush_i,
        output ctrl_o, valid_o, busy_o, illegal_o
    );
endinterface

`default_nettype wire

// File: rtl/alu_ctrl_issue.sv
// ============================================================================
// Module   : alu_ctrl_issue
// Brief    : Decodes ALUOp/funct into the registered EX-stage ALU code and
//            sequences multi-cycle multiplies. Option macro:
//            ALU_CTRL_ILLEGAL_TRAP_EN (sticky illegal flag that blocks issue).
// Revision : 1.0
// ============================================================================
`default_nettype none

module alu_ctrl_issue #(
    parameter int MUL_LAT = 4,
    parameter int CNT_W   = 3
) (
    input  wire logic        clk_i,
    input  wire logic        rst_i,
    alu_ctrl_issue_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ISSUE    = 2'd1,
        ST_MUL_WAIT = 2'd2
    } state_t;

    localparam logic [3:0]       c_CODE_ADD = 4'd2;
    localparam logic [3:0]       c_CODE_SUB = 4'd6;
    localparam logic [3:0]       c_CODE_SLT = 4'd7;
    localparam logic [3:0]       c_CODE_AND = 4'd0;
    localparam logic [3:0]       c_CODE_OR  = 4'd1;
    localparam logic [3:0]       c_CODE_NOR = 4'd12;
    localparam logic [3:0]       c_CODE_MUL = 4'd3;
    localparam logic [3:0]       c_CODE_ILL = 4'd15;
    localparam bit               c_MUL_MULTI = (MUL_LAT > 1);
    localparam logic [CNT_W-1:0] c_MUL_CNT   = c_MUL_MULTI ? CNT_W'(MUL_LAT - 2) : '0;

    state_t           r_state, w_state_nxt;
    logic [3:0]       r_ctrl, w_ctrl_nxt;
    logic             r_valid, w_valid_nxt;
    logic             r_busy, w_busy_nxt;
    logic             r_illegal, w_illegal_nxt;
    logic [CNT_W-1:0] r_count, w_count_nxt;

    logic [3:0]       w_code;
    logic             w_code_illegal;
    logic             w_is_mul;
    logic             w_block;
    logic             w_accept;

    // ------------------------------------------------------------------
    // Combinational decode of the instruction currently presented by ID
    // ------------------------------------------------------------------
    always_comb begin
        w_code         = c_CODE_ILL;
        w_code_illegal = 1'b1;
        case (bus.alu_op_i)
            3'b000: begin w_code = c_CODE_ADD; w_code_illegal = 1'b0; end
            3'b001: begin w_code = c_CODE_SUB; w_code_illegal = 1'b0; end
            3'b011: begin w_code = c_CODE_SLT; w_code_illegal = 1'b0; end
            3'b100: begin w_code = c_CODE_AND; w_code_illegal = 1'b0; end
            3'b101: begin w_code = c_CODE_OR;  w_code_illegal = 1'b0; end
            3'b010: begin
                case (bus.funct_i)
                    6'h20:   begin w_code = c_CODE_ADD; w_code_illegal = 1'b0; end
                    6'h22:   begin w_code = c_CODE_SUB; w_code_illegal = 1'b0; end
                    6'h24:   begin w_code = c_CODE_AND; w_code_illegal = 1'b0; end
                    6'h25:   begin w_code = c_CODE_OR;  w_code_illegal = 1'b0; end
                    6'h2A:   begin w_code = c_CODE_SLT; w_code_illegal = 1'b0; end
                    6'h27:   begin w_code = c_CODE_NOR; w_code_illegal = 1'b0; end
                    6'h18:   begin w_code = c_CODE_MUL; w_code_illegal = 1'b0; end
                    default: begin w_code = c_CODE_ILL; w_code_illegal = 1'b1; end
                endcase
            end
            default: begin w_code = c_CODE_ILL; w_code_illegal = 1'b1; end
        endcase
    end

    assign w_is_mul = (bus.alu_op_i == 3'b010) && (bus.funct_i == 6'h18);

`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
    // A trapped illegal op keeps ID blocked until the slot is flushed.
    assign w_block = r_busy | r_illegal;
`else
    assign w_block = r_busy;
`endif

    assign w_accept = bus.valid_i & ~w_block & ~bus.stall_i & ~bus.flush_i;

    // ------------------------------------------------------------------
    // Next-state and next-output logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt   = r_state;
        w_ctrl_nxt    = r_ctrl;
        w_valid_nxt   = r_valid;
        w_busy_nxt    = r_busy;
        w_illegal_nxt = r_illegal;
        w_count_nxt   = r_count;

        if (bus.flush_i) begin
            w_state_nxt   = ST_IDLE;
            w_valid_nxt   = 1'b0;
            w_busy_nxt    = 1'b0;
            w_illegal_nxt = 1'b0;
            w_count_nxt   = '0;
        end else if (!bus.stall_i) begin
            case (r_state)
                ST_MUL_WAIT: begin
                    if (r_count == '0) begin
                        w_state_nxt = ST_ISSUE;
                        w_valid_nxt = 1'b1;
                        w_busy_nxt  = 1'b0;
                    end else begin
                        w_count_nxt = r_count - CNT_W'(1);
                    end
                end
                default: begin
                    if (w_accept) begin
                        if (w_is_mul && c_MUL_MULTI) begin
                            w_state_nxt   = ST_MUL_WAIT;
                            w_ctrl_nxt    = c_CODE_MUL;
                            w_valid_nxt   = 1'b0;
                            w_busy_nxt    = 1'b1;
                            w_illegal_nxt = 1'b0;
                            w_count_nxt   = c_MUL_CNT;
                        end else begin
                            w_state_nxt   = ST_ISSUE;
                            w_ctrl_nxt    = w_code;
                            w_valid_nxt   = 1'b1;
                            w_illegal_nxt = w_code_illegal;
                        end
                    end else begin
                        // ctrl and illegal keep describing the last accepted op.
                        w_state_nxt = ST_IDLE;
                        w_valid_nxt = 1'b0;
                    end
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state   <= ST_IDLE;
            r_ctrl    <= 4'd0;
            r_valid   <= 1'b0;
            r_busy    <= 1'b0;
            r_illegal <= 1'b0;
            r_count   <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_ctrl    <= w_ctrl_nxt;
            r_valid   <= w_valid_nxt;
            r_busy    <= w_busy_nxt;
            r_illegal <= w_illegal_nxt;
            r_count   <= w_count_nxt;
        end
    end

    assign bus.ctrl_o    = r_ctrl;
    assign bus.valid_o   = r_valid;
    assign bus.busy_o    = w_block;
    assign bus.illegal_o = r_illegal;

endmodule

`default_nettype wire

// File: tb/tb_alu_ctrl_issue.sv
// ============================================================================
// Module   : tb_alu_ctrl_issue
// Brief    : Directed and randomized self-checking bench for alu_ctrl_issue.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_alu_ctrl_issue;

    localparam int MUL_LAT = 4;
    localparam int CNT_W   = 3;

    logic clk_i;
    logic rst_i;
    alu_ctrl_issue_if bus ();

    alu_ctrl_issue #(.MUL_LAT(MUL_LAT), .CNT_W(CNT_W)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus.slave)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int total = 0;
    int bad   = 0;

`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: code table straight from the opcode/funct rules.
    function automatic void ref_decode(input logic [2:0] op, input logic [5:0] f,
                                       output int code, output bit ill);
        code = 15;
        ill  = 1'b1;
        case (op)
            3'b000: code = 2;
            3'b001: code = 6;
            3'b011: code = 7;
            3'b100: code = 0;
            3'b101: code = 1;
            3'b010: begin
                case (f)
                    6'h20: code = 2;
                    6'h22: code = 6;
                    6'h24: code = 0;
                    6'h25: code = 1;
                    6'h2A: code = 7;
                    6'h27: code = 12;
                    6'h18: code = 3;
                    default: code = 15;
                endcase
            end
            default: code = 15;
        endcase
        ill = (code == 15);
    endfunction

    // Model: remaining multiply cycles as a plain count; busy means "still counting".
    int m_ctrl    = 0;
    bit m_valid   = 0;
    bit m_illegal = 0;
    int m_remain  = 0;

    function automatic bit m_busy();
        return (m_remain > 0) || (TRAP && m_illegal);
    endfunction

    always @(posedge clk_i or negedge rst_i) begin
        int code;
        bit ill;
        if (!rst_i) begin
            m_ctrl = 0; m_valid = 0; m_illegal = 0; m_remain = 0;
        end else if (bus.flush_i) begin
            m_valid = 0; m_illegal = 0; m_remain = 0;
        end else if (!bus.stall_i) begin
            if (m_remain > 0) begin
                m_remain--;
                m_valid = (m_remain == 0);
            end else if (bus.valid_i && !m_busy()) begin
                ref_decode(bus.alu_op_i, bus.funct_i, code, ill);
                if (code == 3 && MUL_LAT > 1) begin
                    m_ctrl = 3; m_valid = 0; m_illegal = 0; m_remain = MUL_LAT - 1;
                end else begin
                    m_ctrl = code; m_valid = 1; m_illegal = ill;
                end
            end else begin
                m_valid = 0;
            end
        end
    end

    always @(negedge clk_i) begin
        if (rst_i === 1'b1) begin
            chk("model_ctrl",    int'(bus.ctrl_o),    m_ctrl);
            chk("model_valid",   int'(bus.valid_o),   int'(m_valid));
            chk("model_busy",    int'(bus.busy_o),    int'(m_busy()));
            chk("model_illegal", int'(bus.illegal_o), int'(m_illegal));
        end
    end

    task automatic drive(input bit v, input logic [2:0] op, input logic [5:0] f,
                         input bit st, input bit fl);
        bus.valid_i  = v;
        bus.alu_op_i = op;
        bus.funct_i  = f;
        bus.stall_i  = st;
        bus.flush_i  = fl;
    endtask

    task automatic tick();
        @(negedge clk_i);
    endtask

    task automatic chk_outs(input string name, input int c, input int v, input int b, input int il);
        chk({name, "_ctrl"},    int'(bus.ctrl_o),    c);
        chk({name, "_valid"},   int'(bus.valid_o),   v);
        chk({name, "_busy"},    int'(bus.busy_o),    b);
        chk({name, "_illegal"}, int'(bus.illegal_o), il);
    endtask

    logic [5:0] legal_funct [7];

    initial begin
        int exp_c, exp_v, exp_b, exp_i;
        legal_funct = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h27, 6'h18};

        rst_i = 1'b0;
        drive(0, 3'b000, 6'h00, 0, 0);
        repeat (2) tick();
        chk_outs("reset", 0, 0, 0, 0);
        rst_i = 1'b1;
        tick();

        // Back-to-back R-type issue
        drive(1, 3'b010, 6'h20, 0, 0); tick(); chk_outs("b2b_add", 2, 1, 0, 0);
        drive(1, 3'b010, 6'h22, 0, 0); tick(); chk_outs("b2b_sub", 6, 1, 0, 0);
        drive(1, 3'b010, 6'h2A, 0, 0); tick(); chk_outs("b2b_slt", 7, 1, 0, 0);
        drive(1, 3'b010, 6'h27, 0, 0); tick(); chk_outs("b2b_nor", 12, 1, 0, 0);
        drive(0, 3'b000, 6'h00, 0, 0); tick(); chk_outs("b2b_idle", 12, 0, 0, 0);

        // Multiply with an add held behind it
        drive(1, 3'b010, 6'h18, 0, 0); tick(); chk_outs("mul_c1", 3, 0, 1, 0);
        drive(1, 3'b000, 6'h00, 0, 0); tick(); chk_outs("mul_c2", 3, 0, 1, 0);
        tick(); chk_outs("mul_c3", 3, 0, 1, 0);
        tick(); chk_outs("mul_done", 3, 1, 0, 0);
        tick(); chk_outs("mul_then_add", 2, 1, 0, 0);
        drive(0, 3'b000, 6'h00, 0, 0); tick();

        // Stall slips multiply completion by two cycles
        drive(1, 3'b010, 6'h18, 0, 0); tick(); chk_outs("mst_c1", 3, 0, 1, 0);
        drive(0, 3'b000, 6'h00, 1, 0); tick(); tick(); chk_outs("mst_stalled", 3, 0, 1, 0);
        drive(0, 3'b000, 6'h00, 0, 0); tick(); tick(); chk_outs("mst_c3", 3, 0, 1, 0);
        tick(); chk_outs("mst_done", 3, 1, 0, 0);
        tick();

        // Flush during multiply drops the same-cycle op
        drive(1, 3'b010, 6'h18, 0, 0); tick();
        drive(1, 3'b000, 6'h00, 0, 1); tick(); chk_outs("flush", 3, 0, 0, 0);
        drive(0, 3'b000, 6'h00, 0, 0); tick(); chk_outs("flush_drop", 3, 0, 0, 0);

        // Illegal ALUOp
        drive(1, 3'b111, 6'h00, 0, 0); tick(); chk_outs("illegal", 15, 1, 0, 1);
        drive(1, 3'b000, 6'h00, 0, 0); tick();
        if (TRAP) begin exp_c = 15; exp_v = 0; exp_b = 1; exp_i = 1; end
        else      begin exp_c = 2;  exp_v = 1; exp_b = 0; exp_i = 0; end
        chk_outs("after_illegal", exp_c, exp_v, exp_b, exp_i);
        drive(1, 3'b000, 6'h00, 0, 1); tick(); chk_outs("ill_flush", exp_c, 0, 0, 0);
        drive(1, 3'b001, 6'h00, 0, 0); tick(); chk_outs("ill_recover", 6, 1, 0, 0);

        // Asynchronous reset mid-multiply
        drive(1, 3'b010, 6'h18, 0, 0); tick();
        drive(0, 3'b000, 6'h00, 0, 0);
        @(posedge clk_i); #3;
        rst_i = 1'b0;
        #1 chk_outs("async_rst", 0, 0, 0, 0);
        tick();
        rst_i = 1'b1;
        tick();

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            logic [2:0] op;
            logic [5:0] f;
            op = ($urandom_range(0, 9) < 6) ? 3'b010 : 3'($urandom);
            f  = ($urandom_range(0, 9) < 8) ? legal_funct[$urandom_range(0, 6)] : 6'($urandom);
            drive($urandom_range(0, 9) < 7, op, f,
                  $urandom_range(0, 99) < 12, $urandom_range(0, 99) < 5);
            tick();
        end

        drive(0, 3'b000, 6'h00, 0, 0);
        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
